// File: rtl/i2c_pkg.sv
// Shared types and constants for the byte-level I2C master.
// Quarter encoding and FSM states live here so the timer and top agree.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } quarter_t;

  localparam int MIN_LIMIT = 2;

endpackage

// File: rtl/i2c_quarter_timer.sv
// Quarter-period timer: latches the divisor at command accept, then
// emits one tick per L cycles and steps the Q0..Q3 phase on each tick.
module i2c_quarter_timer
  import i2c_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_limit,
  input  logic             i_run,
  output logic             o_tick,
  output logic [1:0]       o_phase
);

  logic [DIV_W-1:0] r_lim;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_eff;
  logic             r_wait;
  logic [1:0]       r_phase;

  assign w_eff = (i_limit < DIV_W'(MIN_LIMIT)) ?
                 DIV_W'(MIN_LIMIT) : i_limit;

  // r_wait idles the accept-follow cycle so Q0 starts one cycle later
  assign o_tick = i_run && !r_wait &&
                  (r_cnt == r_lim - DIV_W'(1));

  assign o_phase = r_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lim   <= '0;
      r_cnt   <= '0;
      r_wait  <= 1'b0;
      r_phase <= 2'd0;
    end else if (i_load) begin
      r_lim   <= w_eff;
      r_cnt   <= '0;
      r_wait  <= 1'b1;
      r_phase <= 2'd0;
    end else if (i_run) begin
      if (r_wait) begin
        r_wait <= 1'b0;
      end else if (o_tick) begin
        r_cnt   <= '0;
        r_phase <= r_phase + 2'd1;
      end else begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: optional START, 8 data bits + ACK, optional
// STOP, with the bus left held (SCL/SDA low) between chained bytes.
module i2c_byte_master
  import i2c_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] limit,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             cmd_rw,
  input  logic             cmd_ack,
  input  logic [7:0]       wdata,
  output logic             rsp_valid,
  output logic [7:0]       rdata,
  output logic             rsp_nack,
  output logic             busy,
  output logic             bus_held,
  output logic             scl_oe,
  output logic             sda_oe,
  input  logic             sda_in
);

  state_t     r_state;
  state_t     w_ns;
  logic [3:0] r_bit;
  logic [3:0] w_nbit;
  logic       r_rw;
  logic       r_ack;
  logic       r_stop;
  logic [7:0] r_wdata;
  logic [7:0] r_shift;
  logic [7:0] r_rdata;
  logic       r_nack_s;
  logic       r_rsp_nack;
  logic       r_rsp_valid;
  logic       r_scl_oe;
  logic       r_sda_oe;
  logic       r_held;

  logic       w_ready;
  logic       w_busy;
  logic       w_accept;
  logic       w_tick;
  logic [1:0] w_ph_raw;
  quarter_t   w_phase;
  quarter_t   w_nq;
  logic       w_done;
  logic [2:0] w_idx;
  logic       w_bitsda;
  logic       w_scl;
  logic       w_sda;
  logic       w_held;

  assign w_ready  = (r_state == ST_IDLE) ||
                    (r_state == ST_HOLD);
  assign w_busy   = !w_ready;
  assign w_accept = cmd_valid && w_ready;
  assign w_phase  = quarter_t'(w_ph_raw);

  i2c_quarter_timer #(
    .DIV_W(DIV_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_limit(limit),
    .i_run  (w_busy),
    .o_tick (w_tick),
    .o_phase(w_ph_raw)
  );

  always_comb begin
    w_ns   = r_state;
    w_nbit = r_bit;
    w_done = 1'b0;
    w_nq   = w_tick ? quarter_t'(w_ph_raw + 2'd1) : w_phase;
    if (w_tick && (w_phase == Q3)) begin
      unique case (r_state)
        ST_START: w_ns = ST_DATA;
        ST_DATA: begin
          if (r_bit != 4'd0) begin
            w_nbit = r_bit - 4'd1;
          end else if (r_stop) begin
            w_ns = ST_STOP;
          end else begin
            w_ns   = ST_HOLD;
            w_done = 1'b1;
          end
        end
        ST_STOP: begin
          w_ns   = ST_IDLE;
          w_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Line levels for the quarter about to begin (oe=1 pulls low)
  always_comb begin
    w_idx    = w_nbit[2:0] - 3'd1;
    w_bitsda = (w_nbit == 4'd0) ? (r_rw & ~r_ack)
                                : (~r_rw & ~r_wdata[w_idx]);
    w_scl  = r_scl_oe;
    w_sda  = r_sda_oe;
    w_held = 1'b1;
    unique case (w_ns)
      ST_IDLE: begin
        w_scl  = 1'b0;
        w_sda  = 1'b0;
        w_held = 1'b0;
      end
      ST_HOLD: begin
        w_scl = 1'b1;
        w_sda = 1'b1;
      end
      ST_START: begin
        unique case (w_nq)
          Q0:      w_sda = 1'b0;
          Q1:      w_scl = 1'b0;
          Q2:      w_sda = 1'b1;
          default: w_scl = 1'b1;
        endcase
      end
      ST_DATA: begin
        w_scl = (w_nq == Q0) || (w_nq == Q3);
        w_sda = w_bitsda;
      end
      ST_STOP: begin
        unique case (w_nq)
          Q0: begin
            w_scl = 1'b1;
            w_sda = 1'b1;
          end
          Q1: w_scl = 1'b0;
          Q2: begin
            w_sda  = 1'b0;
            w_held = 1'b0;
          end
          default: begin
            w_scl  = 1'b0;
            w_sda  = 1'b0;
            w_held = 1'b0;
          end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_bit       <= 4'd0;
      r_rw        <= 1'b0;
      r_ack       <= 1'b0;
      r_stop      <= 1'b0;
      r_wdata     <= 8'd0;
      r_shift     <= 8'd0;
      r_rdata     <= 8'd0;
      r_nack_s    <= 1'b0;
      r_rsp_nack  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_scl_oe    <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_held      <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_accept) begin
        r_state <= (cmd_start || (r_state == ST_IDLE)) ?
                   ST_START : ST_DATA;
        r_bit   <= 4'd8;
        r_rw    <= cmd_rw;
        r_ack   <= cmd_ack;
        r_stop  <= cmd_stop;
        r_wdata <= wdata;
      end else begin
        r_state  <= w_ns;
        r_bit    <= w_nbit;
        r_scl_oe <= w_scl;
        r_sda_oe <= w_sda;
        r_held   <= w_held;
        if ((r_state == ST_DATA) && w_tick && (w_phase == Q1)) begin
          if (r_bit != 4'd0) begin
            r_shift <= {r_shift[6:0], sda_in};
          end else begin
            r_nack_s <= sda_in;
          end
        end
        if (w_done) begin
          r_rsp_valid <= 1'b1;
          if (r_rw) begin
            r_rdata    <= r_shift;
            r_rsp_nack <= 1'b0;
          end else begin
            r_rsp_nack <= r_nack_s;
          end
        end
      end
    end
  end

  assign cmd_ready = w_ready;
  assign busy      = w_busy;
  assign bus_held  = r_held;
  assign rsp_valid = r_rsp_valid;
  assign rdata     = r_rdata;
  assign rsp_nack  = r_rsp_nack;
  assign scl_oe    = r_scl_oe;
  assign sda_oe    = r_sda_oe;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Directed bench for i2c_byte_master: bit patterns, latency, repeated
// start, divisor clamping, mid-command reset and ignored inputs.
module tb_i2c_byte_master;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] limit;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_start;
  logic          cmd_stop;
  logic          cmd_rw;
  logic          cmd_ack;
  logic [7:0]    wdata;
  logic          rsp_valid;
  logic [7:0]    rdata;
  logic          rsp_nack;
  logic          busy;
  logic          bus_held;
  logic          scl_oe;
  logic          sda_oe;
  logic          sda_in;

  int checks = 0;
  int errors = 0;

  int         lat;
  logic [7:0] pat;
  bit         ackdrv;
  int         acc;
  bit         rs;

  always #5 clk = ~clk;

  i2c_byte_master #(
    .DIV_W(DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .limit    (limit),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_start(cmd_start),
    .cmd_stop (cmd_stop),
    .cmd_rw   (cmd_rw),
    .cmd_ack  (cmd_ack),
    .wdata    (wdata),
    .rsp_valid(rsp_valid),
    .rdata    (rdata),
    .rsp_nack (rsp_nack),
    .busy     (busy),
    .bus_held (bus_held),
    .scl_oe   (scl_oe),
    .sda_oe   (sda_oe),
    .sda_in   (sda_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one command and follows it with a cycle-exact schedule model:
  // cycle c counts from the accept edge; step s quarter q covers
  // cycles 1+4Ls+qL .. 1+4Ls+(q+1)L-1.
  task automatic run_cmd(
    input bit st, input bit sp, input bit rw, input bit ak,
    input logic [7:0] wd, input int lim, input bit est,
    input logic [7:0] sin, input bit sack, input bit keep,
    input int chg_c, input int chg_l, input int rst_c,
    output int lat_o, output logic [7:0] pat_o,
    output bit ackdrv_o, output int acc_o, output bit rs_o);
    int L;
    int off;
    int s;
    int q;
    int j;
    int bound;
    L        = (lim < 2) ? 2 : lim;
    bound    = 4 * L * 12 + 8;
    lat_o    = -1;
    pat_o    = 8'h00;
    ackdrv_o = 1'b0;
    acc_o    = 0;
    rs_o     = 1'b1;
    @(negedge clk);
    cmd_start = st;
    cmd_stop  = sp;
    cmd_rw    = rw;
    cmd_ack   = ak;
    wdata     = wd;
    limit     = lim[DW-1:0];
    cmd_valid = 1'b1;
    chk("accept_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    if (!keep) cmd_valid = 1'b0;
    for (int c = 0; c <= bound; c++) begin
      if (c == rst_c) begin
        rst_n = 1'b0;
        #1;
        chk("rst_scl_oe", scl_oe, 0);
        chk("rst_sda_oe", sda_oe, 0);
        cmd_valid = 1'b0;
        sda_in    = 1'b1;
        return;
      end
      if (rsp_valid) begin
        lat_o = c;
        break;
      end
      if (cmd_valid && cmd_ready) acc_o++;
      if (c == chg_c) limit = chg_l[DW-1:0];
      sda_in = 1'b1;
      if (c >= 1) begin
        off = c - 1;
        s   = off / (4 * L);
        q   = (off % (4 * L)) / L;
        j   = s - (est ? 1 : 0);
        if (j >= 0 && j <= 8) sda_in = (j < 8) ? sin[7-j] : sack;
        if (j >= 0 && j < 8 && q == 1 && (off % L) == 0)
          pat_o[7-j] = ~sda_oe;
        if (j == 8 && sda_oe) ackdrv_o = 1'b1;
        if (est && s == 0 && q == 1 && (off % L) == 0 &&
            (scl_oe || sda_oe)) rs_o = 1'b0;
        if (est && s == 0 && q == 2 && (off % L) == 0 &&
            (scl_oe || !sda_oe)) rs_o = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    sda_in    = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    limit     = 16'd4;
    cmd_valid = 1'b0;
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;
    cmd_rw    = 1'b0;
    cmd_ack   = 1'b0;
    wdata     = 8'h00;
    sda_in    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_held", bus_held, 0);
    chk("rst_scl", scl_oe, 0);
    chk("rst_sda", sda_oe, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_nack", rsp_nack, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // write 0xA5, start+stop, acked
    run_cmd(1, 1, 0, 0, 8'hA5, 4, 1, 8'h00, 0, 0, -1, 0, -1,
            lat, pat, ackdrv, acc, rs);
    chk("wr_lat", lat, 177);
    chk("wr_pat", pat, 8'hA5);
    chk("wr_nack", rsp_nack, 0);
    chk("wr_start_shape", rs, 1);
    @(posedge clk);
    #1;
    chk("wr_idle_busy", busy, 0);
    chk("wr_idle_held", bus_held, 0);
    chk("wr_idle_scl", scl_oe, 0);
    chk("wr_idle_sda", sda_oe, 0);

    // read 0x3C with NACK sent
    run_cmd(1, 1, 1, 1, 8'h00, 4, 1, 8'h3C, 1, 0, -1, 0, -1,
            lat, pat, ackdrv, acc, rs);
    chk("rd_lat", lat, 177);
    chk("rd_data", rdata, 8'h3C);
    chk("rd_ack_released", ackdrv, 0);
    chk("rd_nack", rsp_nack, 0);

    // write 0x10 start no stop, slave NACKs
    run_cmd(1, 0, 0, 0, 8'h10, 4, 1, 8'h00, 1, 0, -1, 0, -1,
            lat, pat, ackdrv, acc, rs);
    chk("hold_lat", lat, 161);
    chk("hold_nack", rsp_nack, 1);
    chk("hold_pat", pat, 8'h10);
    @(posedge clk);
    #1;
    chk("hold_held", bus_held, 1);
    chk("hold_scl", scl_oe, 1);
    chk("hold_sda", sda_oe, 1);
    chk("hold_ready", cmd_ready, 1);
    chk("hold_busy", busy, 0);

    // repeated start, read 0x81 with ACK driven
    run_cmd(1, 1, 1, 0, 8'h00, 4, 1, 8'h81, 1, 0, -1, 0, -1,
            lat, pat, ackdrv, acc, rs);
    chk("rs_shape", rs, 1);
    chk("rs_lat", lat, 177);
    chk("rs_data", rdata, 8'h81);
    chk("rs_ack_driven", ackdrv, 1);
    chk("rs_nack", rsp_nack, 0);

    // divisor clamp: limit 0/1/2 all act as L=2
    run_cmd(1, 0, 0, 0, 8'hC3, 0, 1, 8'h00, 0, 0, -1, 0, -1,
            lat, pat, ackdrv, acc, rs);
    chk("l0_lat", lat, 81);
    chk("l0_pat", pat, 8'hC3);
    run_cmd(0, 0, 0, 0, 8'h5A, 1, 0, 8'h00, 0, 0, -1, 0, -1,
            lat, pat, ackdrv, acc, rs);
    chk("l1_lat", lat, 73);
    chk("l1_pat", pat, 8'h5A);
    run_cmd(0, 0, 0, 0, 8'h96, 2, 0, 8'h00, 1, 0, -1, 0, -1,
            lat, pat, ackdrv, acc, rs);
    chk("l2_lat", lat, 73);
    chk("l2_nack", rsp_nack, 1);
    run_cmd(0, 1, 0, 0, 8'h3F, 0, 0, 8'h00, 0, 0, -1, 0, -1,
            lat, pat, ackdrv, acc, rs);
    chk("l0stop_lat", lat, 81);
    chk("l0stop_nack", rsp_nack, 0);
    @(posedge clk);
    #1;
    chk("l0stop_held", bus_held, 0);

    // cmd_valid held and limit changed mid-command
    run_cmd(1, 1, 0, 0, 8'h77, 4, 1, 8'h00, 0, 1, 40, 8, -1,
            lat, pat, ackdrv, acc, rs);
    chk("busy_lat", lat, 177);
    chk("busy_accepts", acc, 0);
    chk("busy_pat", pat, 8'h77);
    limit = 16'd4;

    // reset during data bit 4
    run_cmd(1, 1, 0, 0, 8'hFF, 4, 1, 8'h00, 0, 0, -1, 0, 85,
            lat, pat, ackdrv, acc, rs);
    chk("mrst_ready", cmd_ready, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_rsp", rsp_valid, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("mrst_rsp_late", rsp_valid, 0);
    chk("mrst_held", bus_held, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(0, 1, 0, 0, 8'h3C, 4, 1, 8'h00, 0, 0, -1, 0, -1,
            lat, pat, ackdrv, acc, rs);
    chk("post_rst_start", rs, 1);
    chk("post_rst_lat", lat, 177);
    chk("post_rst_pat", pat, 8'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_byte_master.md
I2C_BYTE_MASTER -- requirements
Module: i2c_byte_master

Interface
REQ-001 Parameter DIV_W, default 16: width of the quarter-period divisor.
REQ-002 clk  in  1  sole clock, all logic on posedge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 limit  in  DIV_W  SCL quarter-period in clk cycles; sampled at command accept.
REQ-005 cmd_valid  in  1 / cmd_ready  out  1  command handshake; transfer when both high on a clk edge.
REQ-006 cmd_start, cmd_stop, cmd_rw, cmd_ack  in  1 each  START before the byte, STOP after it, 0=write/1=read, ACK level to send on a read (0=ACK).
REQ-007 wdata  in  8  byte to write, MSB first.
REQ-008 rsp_valid  out  1  one-cycle completion pulse; rdata  out  8  read byte; rsp_nack  out  1  sampled ACK bit of a write.
REQ-009 busy  out  1  command in progress; bus_held  out  1  bus owned with no STOP issued.
REQ-010 scl_oe, sda_oe  out  1  open-drain pull-low enables (1 = drive 0); sda_in  in  1  SDA pad level.

Function
REQ-011 States IDLE, HOLD, START, DATA, STOP; cmd_ready=1 only in IDLE and HOLD; busy=1 in START, DATA, STOP.
REQ-012 Accepted command enters START if cmd_start=1 or state was IDLE, else DATA; the first quarter begins the cycle after acceptance.
REQ-013 Effective limit L = max(limit, 2); L is latched at acceptance and held constant for the whole command.
REQ-014 Every bus step is four quarters Q0..Q3 of L cycles each, timed by one tick per L cycles.
REQ-015 START: Q0 SDA released, SCL unchanged; Q1 SCL released; Q2 SDA low; Q3 SCL low. This covers both start-from-idle and repeated start from HOLD.
REQ-016 DATA bit (9 bits, bit counter 8..0): Q0 SCL low, SDA updated; Q1-Q2 SCL released; Q3 SCL low; sda_in sampled on the last cycle of Q1.
REQ-017 Write: bits 8..1 drive wdata[7..0]; ack bit releases SDA; sampled value goes to rsp_nack.
REQ-018 Read: bits 8..1 release SDA and shift sda_in into rdata MSB first; ack bit drives cmd_ack; rsp_nack=0.
REQ-019 STOP: Q0 SCL low, SDA low; Q1 SCL released; Q2 SDA released; Q3 idle. Next state is IDLE.
REQ-020 After DATA without cmd_stop, next state is HOLD with SCL low, SDA low; bus_held=1 in HOLD, START and DATA, 0 in IDLE and after STOP Q2.
REQ-021 rsp_valid pulses the cycle after the command's final Q3; rdata and rsp_nack hold until the next rsp_valid.
REQ-022 Latency from acceptance to rsp_valid is exactly 4*L*(9 + cmd_start + cmd_stop) + 1 cycles, where cmd_start counts 1 when forced from IDLE.
REQ-023 cmd_valid while busy is not accepted; other inputs are ignored outside the accept cycle except sda_in.
REQ-024 Changes to limit mid-command have no effect until the next acceptance.

Reset
REQ-025 rst_n low asynchronously forces IDLE, scl_oe=0, sda_oe=0, busy=0, bus_held=0, rsp_valid=0, rdata=0, rsp_nack=0, cmd_ready=1, bit and divisor counters=0.
REQ-026 Reset mid-transfer releases both lines immediately, issues no STOP and no rsp_valid; the first edge after release is in IDLE.

Structure
REQ-027 Shared package i2c_pkg holds the state enumeration, quarter encoding and constant MIN_LIMIT=2.
REQ-028 One sub-module, i2c_quarter_timer, holds the DIV_W counter, L latch and Q0..Q3 phase counter, and emits the tick and phase.

Verification
REQ-029 With L=4, write 0xA5 with start+stop and sda_in=0 on the ack bit -> SDA bit pattern 1,0,1,0,0,1,0,1; rsp_nack=0; rsp_valid 177 cycles after accept.
REQ-030 With L=4, read with start+stop, cmd_ack=1 and sda_in serialising 0x3C -> rdata=0x3C; sda_oe=0 throughout the ack bit; rsp_valid at 177.
REQ-031 Write 0x10 with start and no stop, sda_in=1 on ack -> rsp_nack=1 at cycle 161; state HOLD, bus_held=1, scl_oe=1; then start+read+stop -> repeated-start SDA falls while SCL released.
REQ-032 limit=0 and limit=1 -> identical timing to limit=2 (write with no start/stop from HOLD completes in 73 cycles).
REQ-033 rst_n asserted at bit 4 of a write -> scl_oe=sda_oe=0 in the same cycle; no rsp_valid; cmd_ready=1; the next command begins with START.
REQ-034 cmd_valid held during a busy command, then limit changed from 4 to 8 mid-command -> no second accept before rsp_valid; current command keeps L=4.
